// File: rtl/fp_mult_pkg.sv
// Shared floating-point multiplier definitions.
// Provides the default significand width (hidden bit included), the
// two's-complement exponent width and the derived full product width
// used by the multiplier back end (carry-propagate add + normalize).
`timescale 1ns/1ps
package fp_mult_pkg;
  localparam int MANT_W = 24;
  localparam int EXP_W  = 10;
  localparam int PROD_W = 2 * MANT_W;
endpackage

// File: rtl/mult_cpa_norm_cpa24.sv
// cpa24: plain carry-propagate adder slice used for each half of the
// product (24 bits at the default width).
// Ports:
//   a, b  - addends
//   cin   - carry in
//   sum   - a + b + cin, low W bits
//   cout  - carry out of the slice
`timescale 1ns/1ps
module cpa24 #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/mult_cpa_norm.sv
// mult_cpa_norm: resolves the redundant (sum, carry) product from the
// reduction tree into a binary product and normalizes it.
//   S1: low-half add, registers low sum, low carry-out, high halves,
//       exponent and sign.
//   S2: high-half add with the S1 carry, combinational normalization,
//       then the output registers.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   in_valid / in_ready       - input handshake
//   sum_in, carry_in          - redundant product vectors (2*MANT_W)
//   exp_in, sign_in           - unbiased exponent sum, product sign
//   out_valid / out_ready     - output handshake
//   mant_out                  - normalized significand
//   guard/round/sticky_out    - rounding bits below mant_out
//   exp_out, sign_out         - adjusted exponent, sign
//   zero_out                  - product is exactly zero
`timescale 1ns/1ps
module mult_cpa_norm
  import fp_mult_pkg::*;
#(
  parameter int MANT_W = fp_mult_pkg::MANT_W,
  parameter int EXP_W  = fp_mult_pkg::EXP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*MANT_W-1:0]   sum_in,
  input  logic [2*MANT_W-1:0]   carry_in,
  input  logic [EXP_W-1:0]      exp_in,
  input  logic                  sign_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MANT_W-1:0]     mant_out,
  output logic                  guard_out,
  output logic                  round_out,
  output logic                  sticky_out,
  output logic [EXP_W-1:0]      exp_out,
  output logic                  sign_out,
  output logic                  zero_out
);
  localparam int PW = 2 * MANT_W;

  // ---------------- Stage 1 ----------------
  logic [MANT_W-1:0] lo_sum;
  logic              lo_cout;

  cpa24 #(.W(MANT_W)) u_cpa_lo (
    .a    (sum_in[MANT_W-1:0]),
    .b    (carry_in[MANT_W-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  logic              s1_valid;
  logic [MANT_W-1:0] s1_lo;
  logic              s1_cy;
  logic [MANT_W-1:0] s1_sum_hi;
  logic [MANT_W-1:0] s1_carry_hi;
  logic [EXP_W-1:0]  s1_exp;
  logic              s1_sign;

  // ---------------- Stage 2 ----------------
  logic [MANT_W-1:0] hi_sum;
  logic              hi_cout; // product carry-out is discarded (mod 2^PW)

  cpa24 #(.W(MANT_W)) u_cpa_hi (
    .a    (s1_sum_hi),
    .b    (s1_carry_hi),
    .cin  (s1_cy),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  logic [PW-1:0] prod;
  assign prod = {hi_sum, s1_lo};

  logic [MANT_W-1:0] n_mant;
  logic              n_guard, n_round, n_sticky, n_zero;
  logic [EXP_W-1:0]  n_exp;

  always_comb begin
    n_mant   = '0;
    n_guard  = 1'b0;
    n_round  = 1'b0;
    n_sticky = 1'b0;
    n_exp    = '0;
    n_zero   = 1'b0;
    if (prod == '0) begin
      n_zero = 1'b1;
    end else if (prod[PW-1]) begin
      // Product in [2,4): take the top MANT_W bits and bump the exponent.
      n_mant   = prod[PW-1:MANT_W];
      n_guard  = prod[MANT_W-1];
      n_round  = prod[MANT_W-2];
      n_sticky = |prod[MANT_W-3:0];
      n_exp    = s1_exp + EXP_W'(1);
    end else begin
      // Product in [1,2) (or subnormal-ish): shift one position left.
      n_mant   = prod[PW-2:MANT_W-1];
      n_guard  = prod[MANT_W-2];
      n_round  = prod[MANT_W-3];
      n_sticky = |prod[MANT_W-4:0];
      n_exp    = s1_exp;
    end
  end

  // S2 may load when it is empty or its word leaves this cycle.
  logic s2_adv;
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_lo       <= '0;
      s1_cy       <= 1'b0;
      s1_sum_hi   <= '0;
      s1_carry_hi <= '0;
      s1_exp      <= '0;
      s1_sign     <= 1'b0;
      out_valid   <= 1'b0;
      mant_out    <= '0;
      guard_out   <= 1'b0;
      round_out   <= 1'b0;
      sticky_out  <= 1'b0;
      exp_out     <= '0;
      sign_out    <= 1'b0;
      zero_out    <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_lo       <= lo_sum;
          s1_cy       <= lo_cout;
          s1_sum_hi   <= sum_in[PW-1:MANT_W];
          s1_carry_hi <= carry_in[PW-1:MANT_W];
          s1_exp      <= exp_in;
          s1_sign     <= sign_in;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          mant_out   <= n_mant;
          guard_out  <= n_guard;
          round_out  <= n_round;
          sticky_out <= n_sticky;
          exp_out    <= n_exp;
          sign_out   <= s1_sign;
          zero_out   <= n_zero;
        end
      end
    end
  end
endmodule

// File: tb/tb_mult_cpa_norm.sv
`timescale 1ns/1ps
module tb_mult_cpa_norm;
  typedef struct packed {
    logic [23:0] mant;
    logic        g;
    logic        r;
    logic        s;
    logic [9:0]  e;
    logic        sign;
    logic        zero;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] sum_in;
  logic [47:0] carry_in;
  logic [9:0]  exp_in;
  logic        sign_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] mant_out;
  logic        guard_out, round_out, sticky_out;
  logic [9:0]  exp_out;
  logic        sign_out, zero_out;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mult_cpa_norm #(.MANT_W(24), .EXP_W(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sum_in     (sum_in),
    .carry_in   (carry_in),
    .exp_in     (exp_in),
    .sign_in    (sign_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mant_out   (mant_out),
    .guard_out  (guard_out),
    .round_out  (round_out),
    .sticky_out (sticky_out),
    .exp_out    (exp_out),
    .sign_out   (sign_out),
    .zero_out   (zero_out)
  );

  function automatic exp_t mk(input logic [23:0] m, input logic g, input logic r,
                              input logic s, input logic [9:0] e, input logic sg,
                              input logic z);
    exp_t x;
    x.mant = m; x.g = g; x.r = r; x.s = s; x.e = e; x.sign = sg; x.zero = z;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end else
      $display("ok   %s: %0h", name, got);
  endtask

  // Monitor: samples 1 time unit before each rising edge.
  initial begin
    exp_t got;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && out_valid) begin
        got = mk(mant_out, guard_out, round_out, sticky_out, exp_out, sign_out, zero_out);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_word: unexpected word %0h with empty scoreboard", got);
        end else begin
          if (got !== sb[0]) begin
            errors++;
            $display("FAIL out_word: got %0h expected %0h (out_ready=%b)", got, sb[0], out_ready);
          end else
            $display("ok   out_word: %0h (out_ready=%b)", got, out_ready);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance
  // with in_valid still asserted so calls can run back to back.
  task automatic send(input logic [47:0] s, input logic [47:0] c, input logic [9:0] e,
                      input logic sg, input exp_t x);
    int n;
    n = 0;
    in_valid = 1'b1; sum_in = s; carry_in = c; exp_in = e; sign_in = sg;
    forever begin
      #4;
      if (in_ready) begin
        sb.push_back(x);
        @(negedge clk);
        break;
      end
      @(negedge clk);
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout: in_ready stayed %b expected 1", in_ready);
        break;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; sum_in = '0; carry_in = '0; exp_in = '0; sign_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d words left expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_outputs", 64'({mant_out, guard_out, round_out, sticky_out, exp_out, sign_out, zero_out}), 64'd0);
    @(negedge clk);

    // 1.0 x 1.0, with latency check
    send(48'h4000_0000_0000, 48'h0, 10'd0, 1'b0, mk(24'h800000, 0, 0, 0, 10'd0, 0, 0));
    idle();
    #4;
    chk("latency_cycle1_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk); #4;
    chk("latency_cycle2_out_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    drain();

    // Directed vectors, back to back
    send(48'h7FFF_FFFF_FFFF, 48'h1, 10'd5, 1'b0, mk(24'h800000, 0, 0, 0, 10'd6, 0, 0));
    send(48'hFFFF_FE00_0001, 48'h0, 10'h3FD, 1'b1, mk(24'hFFFFFE, 0, 0, 1, 10'h3FE, 1, 0));
    send(48'h0, 48'h0, 10'd9, 1'b1, mk(24'h0, 0, 0, 0, 10'd0, 1, 1));
    send(48'h0000_0100_0000, 48'h0000_0100_0000, 10'd7, 1'b0, mk(24'h000004, 0, 0, 0, 10'd7, 0, 0));
    send(48'h6000_00C0_0003, 48'h0, 10'h3FF, 1'b1, mk(24'hC00001, 1, 0, 1, 10'h3FF, 1, 0));
    send(48'h8000_00FF_FFFF, 48'h0000_0040_0001, 10'h1FF, 1'b0, mk(24'h800001, 0, 1, 0, 10'h200, 0, 0));
    send(48'h7FFF_FFFF_FFFF, 48'h1, 10'h3FF, 1'b1, mk(24'h800000, 0, 0, 0, 10'd0, 1, 0));
    idle();
    drain();

    // Backpressure: out_ready low, third word must wait
    out_ready = 1'b0;
    send(48'h4000_0000_0000, 48'h0, 10'd1, 1'b0, mk(24'h800000, 0, 0, 0, 10'd1, 0, 0));
    send(48'h7FFF_FFFF_FFFF, 48'h1, 10'd2, 1'b0, mk(24'h800000, 0, 0, 0, 10'd3, 0, 0));
    in_valid = 1'b1; sum_in = 48'hFFFF_FE00_0001; carry_in = '0; exp_in = 10'd4; sign_in = 1'b1;
    #4;
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    @(negedge clk);
    fork
      send(48'hFFFF_FE00_0001, 48'h0, 10'd4, 1'b1, mk(24'hFFFFFE, 0, 0, 1, 10'd5, 1, 0));
      begin repeat (3) @(negedge clk); out_ready = 1'b1; end
    join
    idle();
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(48'h4000_0000_0000, 48'h0, 10'd11, 1'b0, mk(24'h800000, 0, 0, 0, 10'd11, 0, 0));
    send(48'h4000_0000_0000, 48'h0, 10'd12, 1'b0, mk(24'h800000, 0, 0, 0, 10'd12, 0, 0));
    rst = 1'b1;  // in_valid still high: must not be accepted
    @(negedge clk);
    rst = 1'b0;
    idle();
    sb.delete();
    #4;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Traffic still flows after reset
    send(48'h0, 48'h0, 10'd3, 1'b0, mk(24'h0, 0, 0, 0, 10'd0, 0, 1));
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mult_cpa_norm.md
MULT_CPA_NORM -- requirements
Module: mult_cpa_norm

Interface
REQ-001 SHALL have parameter MANT_W, default 24, meaning significand width including the hidden bit.
REQ-002 SHALL have parameter EXP_W, default 10, meaning the two's-complement exponent width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the input word is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts the input this cycle.
REQ-007 SHALL have port sum_in, input, 2*MANT_W, the redundant sum vector from the reduction tree.
REQ-008 SHALL have port carry_in, input, 2*MANT_W, the redundant carry vector, already bit-aligned.
REQ-009 SHALL have port exp_in, input, EXP_W, the unbiased exponent sum.
REQ-010 SHALL have port sign_in, input, 1, the product sign.
REQ-011 SHALL have port out_valid, output, 1, and port out_ready, input, 1, the output handshake.
REQ-012 SHALL have port mant_out, output, MANT_W, the normalized significand.
REQ-013 SHALL have ports guard_out, round_out and sticky_out, each output, 1, the rounding bits.
REQ-014 SHALL have ports exp_out (output, EXP_W), sign_out (output, 1) and zero_out (output, 1).

Function
REQ-015 SHALL form P = sum_in + carry_in modulo 2^(2*MANT_W) and discard the carry-out.
REQ-016 SHALL be a 2-stage pipeline.
  - S1 registers the low-half sum, the low-half carry-out, the high halves, exp_in and sign_in.
  - S2 adds the high halves plus the S1 carry, then normalizes.
REQ-017 SHALL transfer on in_valid&&in_ready at the input and on out_valid&&out_ready at the output.
REQ-018 SHALL give a latency of exactly 2 cycles from acceptance to out_valid when out_ready is held high.
REQ-019 SHALL sustain a throughput of 1 word per cycle.
REQ-020 SHALL drive in_ready = !s1_valid || !s2_valid || out_ready; SHALL derive in_ready combinationally from registered state and out_ready only, never from in_valid.
REQ-021 SHALL hold the S2 output registers stable while out_valid && !out_ready.
REQ-022 SHALL let S1 advance into S2 only when S2 is empty or draining in the same cycle.
REQ-023 SHALL neither drop nor duplicate words, and SHALL preserve their order.
REQ-024 SHALL normalize when P[2W-1]=1 (W=MANT_W) as follows.
  - mant = P[2W-1:W], guard = P[W-1], round = P[W-2], sticky = |P[W-3:0].
  - exp_out = exp_in + 1, wrapping modulo 2^EXP_W.
REQ-025 SHALL normalize otherwise as follows.
  - mant = P[2W-2:W-1], guard = P[W-2], round = P[W-3], sticky = |P[W-4:0].
  - exp_out = exp_in.
REQ-026 SHALL, when P == 0, drive zero_out=1, mant_out=0, exp_out=0 and all rounding bits 0; sign_out SHALL still pass through.
REQ-027 SHALL not flag overflow or underflow; exponent range checks belong downstream.

Reset
REQ-028 SHALL, on rst, clear s1_valid and s2_valid and set every output register to 0, so out_valid=0 and in_ready=1 in the cycle after rst.
REQ-029 SHALL, when rst is asserted mid-operation, discard in-flight words; an input presented during rst SHALL not be accepted.
REQ-030 SHALL give rst priority over every handshake event in the same cycle.

Structure
REQ-031 SHALL take MANT_W, EXP_W and the product width 2*MANT_W from the shared fp_mult_pkg package.
REQ-032 SHALL implement each half-add as one instance of sub-module cpa24 (24-bit adder with cin and cout), one instance per stage.
REQ-033 SHALL keep normalization combinational in S2 ahead of the output registers.

Verification
REQ-034 SHALL check 1.0x1.0: sum_in=48'h4000_0000_0000, carry_in=0, exp_in=0 -> after 2 cycles mant_out=24'h800000, guard/round/sticky=0, exp_out=0, zero_out=0.
REQ-035 SHALL check carry crossing the halves: sum_in=48'h7FFF_FFFF_FFFF, carry_in=48'h1, exp_in=5 -> mant_out=24'h800000, exp_out=6, rounding bits 0.
REQ-036 SHALL check the max product: sum_in=48'hFFFF_FE00_0001, carry_in=0, exp_in=-3 -> mant_out=24'hFFFFFE, guard=0, round=0, sticky=1, exp_out=-2.
REQ-037 SHALL check backpressure: 3 back-to-back words with out_ready=0 for 4 cycles.
  - in_ready SHALL drop after 2 acceptances.
  - Outputs SHALL hold stable, then drain in order at 1 per cycle once out_ready=1.
REQ-038 SHALL check reset mid-operation: rst for 1 cycle with both stages full -> next cycle out_valid=0, in_ready=1, no stale word ever emitted.
REQ-039 SHALL check zero: sum_in=carry_in=0, sign_in=1 -> zero_out=1, mant_out=0, exp_out=0, sign_out=1.
